// File: rtl/dm_ctrl.sv
// dm_ctrl: data-memory controller with a fixed-latency read FSM and posted writes.
// Reads are accepted in IDLE, stall the program counter via hold_o for RD_LAT
// cycles, then present the word with a one-cycle rd_valid_o pulse.
// Optional build macro DM_CTRL_STATS_EN adds saturating read/write counters.
module dm_ctrl #(
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] addr_i,
    input  logic        re_i,
    input  logic        we_i,
    input  logic [15:0] wrt_data_i,
    output logic [15:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        hold_o,
    output logic        err_o
`ifdef DM_CTRL_STATS_EN
    ,
    output logic [15:0] rd_cnt_o,
    output logic [15:0] wr_cnt_o
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [2:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    oor_q;
    logic [15:0]             rd_data_q;
    logic                    rd_valid_q;
    logic                    err_q;

    // Storage array; contents survive reset.
    logic [15:0]             mem_q [DEPTH];

    logic                    is_idle;
    logic                    is_busy;
    logic                    oor_in;
    logic                    rd_req;
    logic                    wr_req;
    logic                    conflict;
    logic                    wr_do;
    logic                    err_d;
    logic                    done_d;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    rd_oor;
    logic [2:0]              cnt_load;

    // Load value for the BUSY down-counter; unused when RD_LAT is 1.
    assign cnt_load = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    // Request decode; nothing is accepted while reset is asserted.
    always_comb begin
        is_idle  = (state_q == IDLE) && !rst_i;
        is_busy  = (state_q == BUSY) && !rst_i;
        oor_in   = ((addr_i >> DEPTH_LOG2) != 16'h0000);
        rd_req   = is_idle && re_i && !we_i;
        wr_req   = is_idle && we_i && !re_i;
        conflict = is_idle && re_i && we_i;
        wr_do    = wr_req && !oor_in;
        err_d    = conflict || ((rd_req || wr_req) && oor_in) || (is_busy && we_i);
        // The read completes either straight from IDLE (single-cycle latency)
        // or when the BUSY counter has run out.
        done_d   = (rd_req && (RD_LAT == 1)) || (is_busy && (cnt_q == 3'd0));
        // With single-cycle latency the address has not been latched yet.
        rd_idx   = (state_q == IDLE) ? addr_i[DEPTH_LOG2-1:0] : idx_q;
        rd_oor   = (state_q == IDLE) ? oor_in : oor_q;
    end

    // The CPU stalls from the acceptance cycle until the data is presented.
    assign hold_o     = rd_req || is_busy;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign err_o      = err_q;

    // Posted write: committed on the edge ending the request cycle.
    always_ff @(posedge clk_i) begin
        if (wr_do) begin
            mem_q[addr_i[DEPTH_LOG2-1:0]] <= wrt_data_i;
        end
    end

    // Read FSM with registered data, valid and error outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            idx_q      <= '0;
            oor_q      <= 1'b0;
            rd_data_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= done_d;
            err_q      <= err_d;
            if (done_d) begin
                rd_data_q <= rd_oor ? 16'h0000 : mem_q[rd_idx];
            end
            case (state_q)
                IDLE: begin
                    if (rd_req) begin
                        idx_q <= addr_i[DEPTH_LOG2-1:0];
                        oor_q <= oor_in;
                        if (RD_LAT == 1) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= cnt_load;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DONE: begin
                    // A still-held re must not restart the read here.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef DM_CTRL_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    // Saturating counts of completed reads and performed writes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_cnt_q <= 16'h0000;
            wr_cnt_q <= 16'h0000;
        end else begin
            if ((state_q == DONE) && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (wr_do && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: log2 of the word count of the internal storage array (16-bit words).
REQ-002 Parameter RD_LAT, default 2: read latency in cycles, legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 addr  input  16  word address from the CPU data-memory address mux.
REQ-006 re  input  1  read request, held by the CPU until rd_valid.
REQ-007 we  input  1  write request, single cycle.
REQ-008 wrt_data  input  16  write data.
REQ-009 rd_data  output  16  registered read data.
REQ-010 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-011 hold  output  1  stall to the program counter hold input.
REQ-012 err  output  1  one-cycle pulse flagging an illegal or out-of-range request.

Function
REQ-013 The FSM shall have three states: IDLE, BUSY and DONE.
REQ-014 In IDLE with we=1 and re=0, the block shall write wrt_data to addr at the next rising edge; hold shall stay 0 (posted write, zero wait).
REQ-015 In IDLE with re=1 and we=0 (acceptance cycle T), the block shall latch addr and drive hold=1 combinationally in cycle T.
REQ-016 If RD_LAT>1, the FSM shall go IDLE->BUSY and load a down-counter with RD_LAT-2; if RD_LAT=1, it shall go IDLE->DONE.
REQ-017 BUSY shall hold hold=1 and decrement the counter; it shall go to DONE when the counter is 0.
REQ-018 On entering DONE (cycle T+RD_LAT), rd_data shall show the word at the latched address, rd_valid=1 and hold=0; DONE shall return to IDLE after exactly one cycle.
REQ-019 re and we shall be ignored in DONE, so that a still-asserted re does not restart the read.
REQ-020 rd_data shall hold its last value until the next DONE.
REQ-021 re=1 together with we=1 in IDLE shall pulse err for one cycle, perform no access and leave hold=0.
REQ-022 we=1 in BUSY shall pulse err and be dropped; the pending read shall be unaffected.
REQ-023 An address with addr[15:DEPTH_LOG2] nonzero shall pulse err; such a write shall be dropped, and such a read shall run the normal FSM timing and return 16'h0000.
REQ-024 A write at edge T-1 followed by a read of the same address accepted at T shall return the new data.

Reset
REQ-025 While rst=1, the block shall force: state=IDLE, counter=0, rd_data=16'h0000, rd_valid=0, hold=0, err=0.
REQ-026 Reset during BUSY shall abort the read with no rd_valid pulse.
REQ-027 Storage array contents shall not be reset.

Configuration
REQ-028 The macro shall be DM_CTRL_STATS_EN.
REQ-029 When DM_CTRL_STATS_EN is defined, the block shall add two outputs: rd_cnt (16 bits, completed reads) and wr_cnt (16 bits, performed writes).
REQ-030 rd_cnt and wr_cnt shall saturate at 16'hFFFF, reset to 0, and exclude dropped accesses; rd_cnt shall increment on DONE.
REQ-031 When DM_CTRL_STATS_EN is undefined, the ports and counters shall be absent and all other behaviour shall be identical.

Verification
REQ-032 Reset release, we=1, addr=16'h0005, wrt_data=16'hBEEF, then re=1 at addr 5 next cycle -> hold=1 for 2 cycles, then rd_valid=1 with rd_data=16'hBEEF.
REQ-033 RD_LAT=1: read of addr 0 (preloaded 16'h1234) -> hold=1 for exactly 1 cycle; rd_valid and rd_data=16'h1234 on the next cycle.
REQ-034 re=1 and we=1 together at addr 3 -> err pulse, hold=0, and a subsequent read of addr 3 returns its prior value.
REQ-035 DEPTH_LOG2=10, read at addr 16'h0400 -> err pulse, then after RD_LAT cycles rd_valid=1 with rd_data=16'h0000; write to 16'hFFFF is dropped.
REQ-036 rst asserted one cycle into BUSY with RD_LAT=4 -> no rd_valid, hold=0 immediately, and rd_data=16'h0000.
REQ-037 DM_CTRL_STATS_EN defined: 3 writes, 2 reads, 1 conflict -> wr_cnt=3 and rd_cnt=2.
